// File: rtl/clock_reset_pkg.sv
// rtl/clock_reset_pkg.sv - shared state enum, divide constants and counter width helper
package clock_reset_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    DEBOUNCE  = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } crs_state_e;

  localparam int CPU_DIV = 8;
  localparam int SND_DIV = 12;

  // A terminal count of 1 would give a zero-width counter; keep at least one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clock_reset_sequencer_cen_divider.sv
// rtl/clock_reset_sequencer_cen_divider.sv - mod-DIV clock enable pulse generator
// Ports:
//   clk   - system clock
//   rst_n - synchronous active-low reset
//   run   - counter advances while high, held at 0 while low
//   cen   - registered one-cycle pulse when the counter sits at DIV-1
module cen_divider
  import clock_reset_pkg::*;
#(
  parameter int DIV = CPU_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic cen
);

  localparam int            CW   = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          cen_q, cen_d;

  // Held at zero while stopped so every HOLD entry starts from a known phase.
  // With DIV=1 the counter never leaves 0, so cen stays high while running.
  always_comb begin
    cnt_d = '0;
    cen_d = 1'b0;
    if (run) begin
      cen_d = (cnt_q == LAST);
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      cen_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      cen_q <= cen_d;
    end
  end

  assign cen = cen_q;

endmodule

// File: rtl/clock_reset_sequencer.sv
// rtl/clock_reset_sequencer.sv - PLL-lock debounced system reset and CPU/sound clock enables
// Ports:
//   clk        - 48 MHz system clock
//   rst_n      - synchronous active-low reset
//   pll_locked - PLL lock flag, asynchronous to clk
//   sys_rst    - registered active-high reset to the core
//   ready      - high while in RUN
//   cen_cpu    - one-cycle pulse every DIV_CPU clocks during HOLD/RUN
//   cen_snd    - one-cycle pulse every DIV_SND clocks during HOLD/RUN
module clock_reset_sequencer
  import clock_reset_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CYCLES = 1024,
  parameter int HOLD_CYCLES = 16,
  parameter int DIV_CPU     = CPU_DIV,
  parameter int DIV_SND     = SND_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pll_locked,
  output logic sys_rst,
  output logic ready,
  output logic cen_cpu,
  output logic cen_snd
);

  localparam int            LW        = cnt_width(LOCK_CYCLES);
  localparam int            HW        = cnt_width(HOLD_CYCLES);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   lock_s;
  crs_state_e             state_q, state_d;
  logic [LW-1:0]          lock_cnt_q, lock_cnt_d;
  logic [HW-1:0]          hold_cnt_q, hold_cnt_d;
  logic                   sys_rst_q, sys_rst_d;
  logic                   ready_q, ready_d;
  logic                   div_run;

  // Only the first flop of this chain looks at pll_locked.
  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], pll_locked};
  assign lock_s = sync_q[SYNC_STAGES-1];

  // State register and counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q     <= '0;
      state_q    <= WAIT_LOCK;
      lock_cnt_q <= '0;
      hold_cnt_q <= '0;
      sys_rst_q  <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      sys_rst_q  <= sys_rst_d;
      ready_q    <= ready_d;
    end
  end

  // Next state. Counters default to zero, so any exit from a counting state
  // (lock loss or terminal count) leaves them cleared. Lock loss is tested
  // first so it wins over a coincident terminal count.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = '0;
    hold_cnt_d = '0;
    case (state_q)
      WAIT_LOCK: begin
        if (lock_s) state_d = DEBOUNCE;
      end
      DEBOUNCE: begin
        if (!lock_s)                      state_d = WAIT_LOCK;
        else if (lock_cnt_q == LOCK_LAST) state_d = HOLD;
        else                              lock_cnt_d = lock_cnt_q + LW'(1);
      end
      HOLD: begin
        if (!lock_s)                      state_d = WAIT_LOCK;
        else if (hold_cnt_q == HOLD_LAST) state_d = RUN;
        else                              hold_cnt_d = hold_cnt_q + HW'(1);
      end
      RUN: begin
        if (!lock_s) state_d = WAIT_LOCK;
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  // Outputs decoded from the current state and registered, so sys_rst, ready
  // and both enables all move together one edge after the state changes.
  always_comb begin
    sys_rst_d = (state_q != RUN);
    ready_d   = (state_q == RUN);
    div_run   = (state_q == HOLD) || (state_q == RUN);
  end

  cen_divider #(.DIV(DIV_CPU)) u_cen_cpu (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (div_run),
    .cen   (cen_cpu)
  );

  cen_divider #(.DIV(DIV_SND)) u_cen_snd (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (div_run),
    .cen   (cen_snd)
  );

  assign sys_rst = sys_rst_q;
  assign ready   = ready_q;

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// tb/tb_clock_reset_sequencer.sv - directed self-checking bench for clock_reset_sequencer
module tb_clock_reset_sequencer;
  import clock_reset_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pll_locked = 1'b0;
  logic sys_rst, ready, cen_cpu, cen_snd;
  logic pll_s = 1'b0;
  logic sys_rst_s, ready_s, cen_cpu_s, cen_snd_s;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  clock_reset_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .cen_cpu    (cen_cpu),
    .cen_snd    (cen_snd)
  );

  clock_reset_sequencer #(
    .LOCK_CYCLES (4),
    .HOLD_CYCLES (2),
    .DIV_CPU     (1)
  ) dut_s (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_s),
    .sys_rst    (sys_rst_s),
    .ready      (ready_s),
    .cen_cpu    (cen_cpu_s),
    .cen_snd    (cen_snd_s)
  );

  // Index 0 is the sample taken just after the first edge that sees the new input.
  task automatic wait_release(input int bound, output int idx);
    idx = -1;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); @(negedge clk);
      if (sys_rst === 1'b0) begin
        idx = i;
        break;
      end
    end
  endtask

  task automatic apply_reset(input logic lock_val);
    @(negedge clk);
    rst_n = 1'b0;
    pll_locked = lock_val;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int rel;
    @(negedge clk);
    rst_n = 1'b0;
    pll_locked = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if ({sys_rst, ready, cen_cpu, cen_snd} !== 4'b1000) begin
        failures++;
        $display("FAIL reset_outputs cyc%0d got sys_rst,ready,cen_cpu,cen_snd=%b%b%b%b expected 1000",
                 c, sys_rst, ready, cen_cpu, cen_snd);
      end
      checks++;
      if (dut.state_q !== WAIT_LOCK) begin
        failures++;
        $display("FAIL reset_state cyc%0d got %0d expected %0d", c, dut.state_q, WAIT_LOCK);
      end
    end
    rst_n = 1'b1;
    wait_release(1200, rel);
    checks++;
    if (rel !== 1043) begin
      failures++;
      $display("FAIL reset_release_latency got %0d expected 1043", rel);
    end
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_at_release got %b expected 1", ready);
    end
  endtask

  task automatic test_dividers();
    int err_cpu = 0, err_snd = 0, n_cpu = 0, n_snd = 0, first_cpu = -1, rel = -1;
    logic exp_cpu, exp_snd;
    apply_reset(1'b1);
    for (int idx = 0; idx < 1110; idx++) begin
      @(posedge clk); @(negedge clk);
      exp_cpu = (idx >= 1034) && ((idx - 1034) % 8 == 0);
      exp_snd = (idx >= 1038) && ((idx - 1038) % 12 == 0);
      if (cen_cpu !== exp_cpu) err_cpu++;
      if (cen_snd !== exp_snd) err_snd++;
      if (idx >= 1027 && idx < 1075) begin
        if (cen_cpu === 1'b1) n_cpu++;
        if (cen_snd === 1'b1) n_snd++;
      end
      if (first_cpu < 0 && cen_cpu === 1'b1) first_cpu = idx;
      if (rel < 0 && sys_rst === 1'b0) rel = idx;
    end
    checks++;
    if (err_cpu !== 0) begin
      failures++;
      $display("FAIL div_cpu_pattern got %0d wrong cycles expected 0", err_cpu);
    end
    checks++;
    if (err_snd !== 0) begin
      failures++;
      $display("FAIL div_snd_pattern got %0d wrong cycles expected 0", err_snd);
    end
    checks++;
    if (n_cpu !== 6) begin
      failures++;
      $display("FAIL div_cpu_count48 got %0d expected 6", n_cpu);
    end
    checks++;
    if (n_snd !== 4) begin
      failures++;
      $display("FAIL div_snd_count48 got %0d expected 4", n_snd);
    end
    checks++;
    if (first_cpu !== 1034) begin
      failures++;
      $display("FAIL div_cpu_first got %0d expected 1034", first_cpu);
    end
    checks++;
    if (rel !== 1043) begin
      failures++;
      $display("FAIL div_release got %0d expected 1043", rel);
    end
  endtask

  task automatic test_glitch();
    int err = 0, rel;
    apply_reset(1'b0);
    pll_locked = 1'b1;
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); @(negedge clk);
      if (sys_rst !== 1'b1) err++;
    end
    pll_locked = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); @(negedge clk);
      if (sys_rst !== 1'b1) err++;
    end
    pll_locked = 1'b1;
    wait_release(1200, rel);
    checks++;
    if (err !== 0) begin
      failures++;
      $display("FAIL glitch_sys_rst_held got %0d early-release cycles expected 0", err);
    end
    checks++;
    if (rel !== 1043) begin
      failures++;
      $display("FAIL glitch_release got %0d expected 1043", rel);
    end
  endtask

  task automatic test_lock_loss();
    int cen_err = 0, rel = -1;
    repeat (5) @(negedge clk);
    pll_locked = 1'b0;
    for (int idx = 0; idx < 1200; idx++) begin
      @(posedge clk); @(negedge clk);
      if (idx == 0) pll_locked = 1'b1;
      if (idx == 2) begin
        checks++;
        if ({sys_rst, ready} !== 2'b01) begin
          failures++;
          $display("FAIL loss_still_running got sys_rst,ready=%b%b expected 01", sys_rst, ready);
        end
      end
      if (idx == 3) begin
        checks++;
        if ({sys_rst, ready} !== 2'b10) begin
          failures++;
          $display("FAIL loss_reset_asserted got sys_rst,ready=%b%b expected 10", sys_rst, ready);
        end
      end
      if (idx >= 3 && idx <= 1027 && (cen_cpu !== 1'b0 || cen_snd !== 1'b0)) cen_err++;
      if (idx >= 3 && rel < 0 && sys_rst === 1'b0) begin
        rel = idx;
        break;
      end
    end
    checks++;
    if (cen_err !== 0) begin
      failures++;
      $display("FAIL loss_cens_stopped got %0d active cycles expected 0", cen_err);
    end
    checks++;
    if (rel !== 1044) begin
      failures++;
      $display("FAIL loss_rerelease got %0d expected 1044", rel);
    end
  endtask

  task automatic test_rst_in_hold();
    int rel;
    apply_reset(1'b1);
    for (int idx = 0; idx < 1034; idx++) begin
      @(posedge clk); @(negedge clk);
    end
    checks++;
    if (dut.state_q !== HOLD) begin
      failures++;
      $display("FAIL hold_reached got state %0d expected %0d", dut.state_q, HOLD);
    end
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({sys_rst, ready, cen_cpu, cen_snd} !== 4'b1000) begin
      failures++;
      $display("FAIL hold_rst_outputs got sys_rst,ready,cen_cpu,cen_snd=%b%b%b%b expected 1000",
               sys_rst, ready, cen_cpu, cen_snd);
    end
    checks++;
    if (dut.state_q !== WAIT_LOCK) begin
      failures++;
      $display("FAIL hold_rst_state got %0d expected %0d", dut.state_q, WAIT_LOCK);
    end
    rst_n = 1'b1;
    wait_release(1200, rel);
    checks++;
    if (rel !== 1043) begin
      failures++;
      $display("FAIL hold_rst_rerelease got %0d expected 1043", rel);
    end
  endtask

  task automatic test_sweep();
    int err_cen = 0, err_rdy = 0, rel = -1;
    @(negedge clk);
    rst_n = 1'b0;
    pll_s = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    pll_s = 1'b1;
    for (int idx = 0; idx < 30; idx++) begin
      @(posedge clk); @(negedge clk);
      if (cen_cpu_s !== (idx >= 7)) err_cen++;
      if (ready_s !== (idx >= 9)) err_rdy++;
      if (rel < 0 && sys_rst_s === 1'b0) rel = idx;
    end
    checks++;
    if (rel !== 9) begin
      failures++;
      $display("FAIL sweep_release got %0d expected 9", rel);
    end
    checks++;
    if (err_cen !== 0) begin
      failures++;
      $display("FAIL sweep_cen_cpu_div1 got %0d wrong cycles expected 0", err_cen);
    end
    checks++;
    if (err_rdy !== 0) begin
      failures++;
      $display("FAIL sweep_ready got %0d wrong cycles expected 0", err_rdy);
    end
  endtask

  initial begin
    test_reset();
    test_dividers();
    test_glitch();
    test_lock_loss();
    test_rst_in_hold();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
